// File: rtl/up5bit_count_pkg.sv
// Shared widths, limits and reset value for the 5-bit count unit.
package up5bit_count_pkg;

  localparam int CNT_W = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX       = 5'd31;
  localparam cnt_t CNT_RESET_VAL = 5'd0;

endpackage

// File: rtl/up5bit_count_incr.sv
// Next-state logic for the count unit: increment (wrap or saturate) plus next terminal count.
module up5bit_count_incr
  import up5bit_count_pkg::*;
(
  input  logic i_en,
  input  logic i_sat,
  input  cnt_t i_value,
  output cnt_t o_next,
  output logic o_tc_next
);

  logic w_at_max;

  always_comb begin
    w_at_max = (i_value == CNT_MAX);
    o_next   = i_value;
    if (i_en && !(i_sat && w_at_max)) begin
      o_next = i_value + cnt_t'(1);
    end
    // tc follows the value about to be registered, never the current output
    o_tc_next = (o_next == CNT_MAX);
  end

endmodule

// File: rtl/up5bit_count_unit.sv
// 5-bit up counter with registered terminal count; 1-cycle latency, no backpressure (en=0 stalls).
// Define UP5BIT_COUNT_SATURATE_EN to saturate at the maximum instead of wrapping.
module up5bit_count_unit
  import up5bit_count_pkg::*;
#(
  parameter int               WIDTH     = CNT_W,
  parameter logic [WIDTH-1:0] RESET_VAL = CNT_RESET_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

`ifdef UP5BIT_COUNT_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  cnt_t             w_next;
  logic             w_tc_next;

  up5bit_count_incr u_incr (
    .i_en      (en),
    .i_sat     (SAT_EN),
    .i_value   (r_out),
    .o_next    (w_next),
    .o_tc_next (w_tc_next)
  );

  // Only enabled edges load, so both out and tc are held verbatim while en=0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= RESET_VAL;
      r_tc  <= 1'b0;
    end else if (en) begin
      r_out <= w_next;
      r_tc  <= w_tc_next;
    end
  end

  assign out = r_out;
  assign tc  = r_tc;

endmodule

// File: tb/tb_up5bit_count_unit.sv
// Directed self-checking bench for up5bit_count_unit (wrap or saturate build).
module tb_up5bit_count_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [4:0] out;
  logic       tc;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_cnt;
  logic       exp_tc;

  always #5 clk = ~clk;

  up5bit_count_unit dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .out   (out),
    .tc    (tc)
  );

  function automatic logic [4:0] nxt(input logic [4:0] v);
`ifdef UP5BIT_COUNT_SATURATE_EN
    return (v == 5'd31) ? v : v + 5'd1;
`else
    return v + 5'd1;
`endif
  endfunction

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Advance one rising edge, update the model, then compare on the falling edge
  task automatic edge_chk(input string tag);
    @(negedge clk);
    if (reset && en) begin
      exp_cnt = nxt(exp_cnt);
      exp_tc  = (exp_cnt == 5'd31);
    end
    chk5({tag, "_out"}, out, exp_cnt);
    chk1({tag, "_tc"}, tc, exp_tc);
  endtask

  // Assert reset between clock edges and check the immediate effect
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    exp_cnt = 5'd0;
    exp_tc  = 1'b0;
    chk5({tag, "_out"}, out, 5'd0);
    chk1({tag, "_tc"}, tc, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b1;
    exp_cnt = 5'd0;
    exp_tc  = 1'b0;

    #1;
    chk5("reset_async_out", out, 5'd0);
    chk1("reset_async_tc", tc, 1'b0);
    edge_chk("reset_hold");
    edge_chk("reset_hold");

    // Free run: 50 edges, crossing the 31 -> 0 wrap
    reset = 1'b1;
    for (int i = 0; i < 50; i++) edge_chk("free_run");
`ifdef UP5BIT_COUNT_SATURATE_EN
    chk5("free_run_end", out, 5'd31);
    chk1("free_run_end_tc", tc, 1'b1);
`else
    chk5("free_run_end", out, 5'd18);
    chk1("free_run_end_tc", tc, 1'b0);
`endif

    async_reset("reset_pulse");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) edge_chk("count_to_13");
    chk5("at_13", out, 5'd13);

    // Reset mid-count, held for 5 cycles, then restart from 0
    async_reset("mid_reset");
    for (int i = 0; i < 5; i++) edge_chk("mid_reset_hold");
    reset = 1'b1;
    edge_chk("restart");
    chk5("restart_1", out, 5'd1);
    edge_chk("restart");
    chk5("restart_2", out, 5'd2);
    edge_chk("restart");
    chk5("restart_3", out, 5'd3);

    // Enable hold at 7
    for (int i = 0; i < 4; i++) edge_chk("count_to_7");
    chk5("at_7", out, 5'd7);
    en = 1'b0;
    for (int i = 0; i < 4; i++) edge_chk("en_hold");
    chk5("en_hold_7", out, 5'd7);
    en = 1'b1;
    edge_chk("en_resume");
    chk5("en_resume_8", out, 5'd8);

    // Hold at the terminal count, then step past it
    for (int i = 0; i < 23; i++) edge_chk("count_to_31");
    chk5("at_31", out, 5'd31);
    chk1("at_31_tc", tc, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) edge_chk("tc_hold");
    chk1("tc_hold_tc", tc, 1'b1);
    en = 1'b1;
    edge_chk("past_max");
`ifdef UP5BIT_COUNT_SATURATE_EN
    chk5("past_max_out", out, 5'd31);
    chk1("past_max_tc", tc, 1'b1);
`else
    chk5("past_max_out", out, 5'd0);
    chk1("past_max_tc", tc, 1'b0);
`endif
    for (int i = 0; i < 3; i++) edge_chk("after_max");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
